seg_readback: RTL and testbench

- Receive-side counterpart to the board display path. Samples the six seven-segment buses HEX5..HEX0 and waits until they are stable.
- Decodes each digit back to a 4-bit hex nibble and delivers each new stable 24-bit reading over a valid/ready handshake.
- Used in self-checking benches and on-chip loopback to confirm that the display path shows the intended value.

---
 rtl/seg_readback.sv | 159 +++++++++++++++
 tb/tb_seg_readback.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_readback.sv
// Seven-segment readback: samples six segment buses, waits for a stable
// pattern, decodes it to hex nibbles and offers each new reading on valid/ready.
module seg_readback #(
    parameter int STABLE_CYCLES  = 4,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  hex0,
    input  logic [6:0]  hex1,
    input  logic [6:0]  hex2,
    input  logic [6:0]  hex3,
    input  logic [6:0]  hex4,
    input  logic [6:0]  hex5,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [23:0] out_value,
    output logic [5:0]  out_digit_ok,
    output logic [5:0]  out_blank,
    output logic        out_overrun
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, PEND} state_t;

    logic [41:0]      raw;
    logic [41:0]      cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [41:0]      last_rep_q;
    logic             have_rep_q;
    state_t           state_q, state_d;
    logic [23:0]      value_q;
    logic [5:0]       ok_q, blank_q;
    logic             overrun_q, overrun_d;
    logic             stable_evt, report, load;

    logic [23:0]      dec_value;
    logic [5:0]       dec_ok, dec_blank;

    assign raw = {hex5, hex4, hex3, hex2, hex1, hex0};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_dec
            logic [6:0] seg;
            logic [3:0] nib;
            logic       ok, blank;

            assign seg = ACTIVE_LOW_SEG ? ~raw[gi*7 +: 7] : raw[gi*7 +: 7];

            always_comb begin
                nib   = 4'h0;
                ok    = 1'b1;
                blank = 1'b0;
                case (seg)
                    7'h3F: nib = 4'h0;
                    7'h06: nib = 4'h1;
                    7'h5B: nib = 4'h2;
                    7'h4F: nib = 4'h3;
                    7'h66: nib = 4'h4;
                    7'h6D: nib = 4'h5;
                    7'h7D: nib = 4'h6;
                    7'h07: nib = 4'h7;
                    7'h7F: nib = 4'h8;
                    7'h6F: nib = 4'h9;
                    7'h77: nib = 4'hA;
                    7'h7C: nib = 4'hB;
                    7'h39: nib = 4'hC;
                    7'h5E: nib = 4'hD;
                    7'h79: nib = 4'hE;
                    7'h71: nib = 4'hF;
                    7'h00: blank = 1'b1;
                    default: ok = 1'b0;
                endcase
            end

            assign dec_value[gi*4 +: 4] = nib;
            assign dec_ok[gi]           = ok;
            assign dec_blank[gi]        = blank;
        end
    endgenerate

    // Stability counter saturates; the event fires once per new stable pattern.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (raw != cand_q) begin
            cand_d = raw;
            cnt_d  = CNT_ONE;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign stable_evt = (cnt_d == CNT_MAX) && ((cnt_q != CNT_MAX) || (raw != cand_q));
    assign report     = stable_evt && ((raw != last_rep_q) || !have_rep_q);

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (report) begin
                    state_d   = PEND;
                    load      = 1'b1;
                    overrun_d = 1'b0;
                end
            end
            PEND: begin
                if (report) begin
                    load      = 1'b1;
                    overrun_d = !out_ready;
                end else if (out_ready) begin
                    state_d   = IDLE;
                    overrun_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cand_q     <= '0;
            cnt_q      <= '0;
            last_rep_q <= '0;
            have_rep_q <= 1'b0;
            state_q    <= IDLE;
            value_q    <= '0;
            ok_q       <= '0;
            blank_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
            if (report) begin
                last_rep_q <= raw;
                have_rep_q <= 1'b1;
            end
            if (load) begin
                value_q <= dec_value;
                ok_q    <= dec_ok;
                blank_q <= dec_blank;
            end
        end
    end

    assign out_valid    = (state_q == PEND);
    assign out_value    = value_q;
    assign out_digit_ok = ok_q;
    assign out_blank    = blank_q;
    assign out_overrun  = overrun_q;

endmodule

// File: tb/tb_seg_readback.sv
// Bench for seg_readback: table of segment patterns with expected readings
// queued on drive and checked when out_valid appears, plus handshake sequences.
module tb_seg_readback;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  hex [6];
    logic        out_ready;
    logic        out_valid;
    logic [23:0] out_value;
    logic [5:0]  out_digit_ok;
    logic [5:0]  out_blank;
    logic        out_overrun;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [41:0] raw;
        int          hold;
        bit          rep;
        logic [23:0] val;
        logic [5:0]  ok;
        logic [5:0]  blank;
    } vec_t;

    typedef struct {
        logic [23:0] val;
        logic [5:0]  ok;
        logic [5:0]  blank;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    seg_readback #(.STABLE_CYCLES(4), .ACTIVE_LOW_SEG(1'b1)) dut (
        .clock(clk), .reset(reset),
        .hex0(hex[0]), .hex1(hex[1]), .hex2(hex[2]),
        .hex3(hex[3]), .hex4(hex[4]), .hex5(hex[5]),
        .out_ready(out_ready), .out_valid(out_valid), .out_value(out_value),
        .out_digit_ok(out_digit_ok), .out_blank(out_blank), .out_overrun(out_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic [41:0] r);
        for (int i = 0; i < 6; i++) hex[i] = r[i*7 +: 7];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [41:0] r, input int h, input bit rep,
                                input logic [23:0] v, input logic [5:0] ok, input logic [5:0] bl);
        vec_t x;
        x.raw = r; x.hold = h; x.rep = rep; x.val = v; x.ok = ok; x.blank = bl;
        return x;
    endfunction

    // Every valid cycle with ready held high is exactly one accepted reading.
    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_report: got value %h expected none", out_value);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_value", {8'h0, out_value}, {8'h0, e.val});
                check("rd_ok", {26'h0, out_digit_ok}, {26'h0, e.ok});
                check("rd_blank", {26'h0, out_blank}, {26'h0, e.blank});
                check("rd_overrun", {31'h0, out_overrun}, 32'h0);
            end
        end
    end

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19,
                           S5 = 7'h12, OFF = 7'h7F;

    initial begin
        vecs.push_back(mk({S0, S0, S0, S0, S2, S1}, 6, 1, 24'h000021, 6'h3F, 6'h00));
        vecs.push_back(mk({S0, S0, S0, S0, S2, S1}, 6, 0, 24'h0, 6'h0, 6'h0));
        vecs.push_back(mk({S0, S0, S0, S0, S2, S3}, 2, 0, 24'h0, 6'h0, 6'h0));
        vecs.push_back(mk({S0, S0, S0, S0, S2, S1}, 6, 0, 24'h0, 6'h0, 6'h0));
        vecs.push_back(mk({S0, S0, S0, S0, S2, S3}, 6, 1, 24'h000023, 6'h3F, 6'h00));
        vecs.push_back(mk({S0, S0, 7'h7E, S0, S2, S3}, 6, 1, 24'h000023, 6'b110111, 6'h00));
        vecs.push_back(mk({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 6, 1, 24'hABCDEF, 6'h3F, 6'h00));
        vecs.push_back(mk({7'h00, 7'h10, 7'h19, 7'h12, 7'h02, 7'h78}, 6, 1, 24'h894567, 6'h3F, 6'h00));
        vecs.push_back(mk({OFF, S0, S1, S1, S1, S1}, 6, 1, 24'h001111, 6'h3F, 6'h20));

        // Reset state and first stable reading with ready low.
        reset = 1'b1;
        out_ready = 1'b0;
        drive({6{OFF}});
        step(2);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_value", {8'h0, out_value}, 32'h0);
        check("rst_ok", {26'h0, out_digit_ok}, 32'h0);
        check("rst_blank", {26'h0, out_blank}, 32'h0);
        check("rst_overrun", {31'h0, out_overrun}, 32'h0);
        reset = 1'b0;
        step(3);
        check("blank_valid_early", {31'h0, out_valid}, 32'h0);
        step(1);
        check("blank_valid", {31'h0, out_valid}, 32'h1);
        check("blank_value", {8'h0, out_value}, 32'h0);
        check("blank_blank", {26'h0, out_blank}, 32'h3F);
        check("blank_ok", {26'h0, out_digit_ok}, 32'h3F);
        step(3);
        check("blank_hold", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        step(1);
        check("blank_accept", {31'h0, out_valid}, 32'h0);

        // Table phase: ready held high, readings checked by the monitor.
        mon_en = 1'b1;
        foreach (vecs[k]) begin
            drive(vecs[k].raw);
            if (vecs[k].rep) sb.push_back('{vecs[k].val, vecs[k].ok, vecs[k].blank});
            step(vecs[k].hold);
        end
        step(2);
        mon_en = 1'b0;
        check("sb_drained", sb.size(), 32'h0);

        // Overrun: second reading overwrites an unaccepted one.
        out_ready = 1'b0;
        drive({S0, S0, S0, S0, S0, S1});
        step(4);
        check("ovr_first_valid", {31'h0, out_valid}, 32'h1);
        check("ovr_first_value", {8'h0, out_value}, 32'h000001);
        drive({S0, S0, S0, S0, S0, S2});
        step(4);
        check("ovr_value", {8'h0, out_value}, 32'h000002);
        check("ovr_flag", {31'h0, out_overrun}, 32'h1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("ovr_accept_valid", {31'h0, out_valid}, 32'h0);
        check("ovr_accept_flag", {31'h0, out_overrun}, 32'h0);

        // Ready coinciding with a report.
        drive({S0, S0, S0, S0, S0, S3});
        step(4);
        check("coin_first_valid", {31'h0, out_valid}, 32'h1);
        drive({S0, S0, S0, S0, S0, S4});
        step(3);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("coin_valid", {31'h0, out_valid}, 32'h1);
        check("coin_value", {8'h0, out_value}, 32'h000004);
        check("coin_overrun", {31'h0, out_overrun}, 32'h0);

        // Reset while pending, then the same value is reported again.
        drive({S0, S0, S0, S0, S0, S5});
        step(4);
        check("pend5_value", {8'h0, out_value}, 32'h000005);
        reset = 1'b1;
        step(1);
        check("pend5_rst_valid", {31'h0, out_valid}, 32'h0);
        check("pend5_rst_value", {8'h0, out_value}, 32'h0);
        reset = 1'b0;
        step(3);
        check("rerep_early", {31'h0, out_valid}, 32'h0);
        step(1);
        check("rerep_valid", {31'h0, out_valid}, 32'h1);
        check("rerep_value", {8'h0, out_value}, 32'h000005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
